// File: rtl/data_memory_ws_pkg.sv
// Shared encodings for the wait-state data memory: FSM states, access size codes
// and the enable/disable constants used across the memory and fetch paths.
package data_memory_ws_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_DONE = 2'd2
  } dmem_state_t;

  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int MAX_WAIT_CYCLES = 15;

endpackage

// File: rtl/data_memory_ws_if.sv
// Request/response bus between the MEM stage (master) and the data memory (slave).
interface data_memory_ws_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  MemRead;
  logic                  MemWrite;
  logic                  size;
  logic [DATA_WIDTH-1:0] ReadData;
  logic                  busy;
  logic                  ready;
  logic                  err;

  // Handshake: MemRead/MemWrite act as the request valid and are sampled only while
  // the memory is idle (busy low, ready low); busy stays high until the single-cycle
  // ready pulse, which carries err and ReadData for that request. Requests seen while
  // busy or ready is high are dropped, so the master must hold or re-issue them.
  modport master (
    output address, WriteData, MemRead, MemWrite, size,
    input  ReadData, busy, ready, err
  );

  modport slave (
    input  address, WriteData, MemRead, MemWrite, size,
    output ReadData, busy, ready, err
  );

endinterface

// File: rtl/data_memory_ws_addr_check.sv
// dmem_addr_check: combinational offset and access-legality check against a
// base-relative window of DEPTH_BYTES; shared with the instruction fetch path.
module dmem_addr_check
  import data_memory_ws_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_BYTES = 64,
  parameter int BASE_ADDR   = 1024
) (
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  size,
  input  logic                  is_read,
  input  logic                  is_write,
  output logic [ADDR_WIDTH-1:0] offset,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(DEPTH_BYTES);
  localparam logic [ADDR_WIDTH-1:0] BPW   = ADDR_WIDTH'(DATA_WIDTH / 8);

  logic [ADDR_WIDTH-1:0] nbytes;
  logic below, overrun, misaligned, conflict;

  always_comb begin
    offset     = address - BASE;
    nbytes     = (size == SIZE_BYTE) ? ADDR_WIDTH'(1) : BPW;
    below      = (address < BASE);
    // Compared as offset > DEPTH - nbytes so the sum can never wrap.
    overrun    = (offset > (DEPTH - nbytes));
    misaligned = (size == SIZE_WORD) && ((offset % BPW) != '0);
    conflict   = is_read && is_write;
    err        = below || overrun || misaligned || conflict;
  end

endmodule

// File: rtl/data_memory_ws.sv
// Big-endian, base-offset data memory with a WAIT_CYCLES busy/ready handshake.
// Byte loads/stores are honoured only when DMEM_BYTE_ACCESS_EN is defined.
module data_memory_ws
  import data_memory_ws_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_BYTES = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst,
  data_memory_ws_if.slave    bus,
  output dmem_state_t        fsm_state
);

  localparam int BPW   = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  logic [7:0] mem [DEPTH_BYTES];

  dmem_state_t           state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  lat_size;
  logic                  lat_rd;
  logic                  lat_wr;

  logic [DATA_WIDTH-1:0] read_data_q;
  logic                  busy_q;
  logic                  ready_q;
  logic                  err_q;

  logic                  req_sel;
  logic                  request;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic                  cur_size;
  logic                  cur_rd;
  logic                  cur_wr;
  logic                  eff_size;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  chk_err;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  complete;
  logic                  unused_bits;

  // With zero wait states the access completes on the acceptance edge itself, so
  // the live inputs are used while idle and the latched copy afterwards.
  assign req_sel   = (state == DMEM_IDLE);
  assign request   = bus.MemRead || bus.MemWrite;
  assign cur_addr  = req_sel ? bus.address   : lat_addr;
  assign cur_wdata = req_sel ? bus.WriteData : lat_wdata;
  assign cur_size  = req_sel ? bus.size      : lat_size;
  assign cur_rd    = req_sel ? bus.MemRead   : lat_rd;
  assign cur_wr    = req_sel ? bus.MemWrite  : lat_wr;

`ifdef DMEM_BYTE_ACCESS_EN
  assign eff_size    = cur_size;
  assign unused_bits = &{1'b0, offset[ADDR_WIDTH-1:IDX_W]};
`else
  assign eff_size    = SIZE_WORD;
  assign unused_bits = &{1'b0, cur_size, offset[ADDR_WIDTH-1:IDX_W]};
`endif

  dmem_addr_check #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DEPTH_BYTES (DEPTH_BYTES),
    .BASE_ADDR   (BASE_ADDR)
  ) u_addr_check (
    .address  (cur_addr),
    .size     (eff_size),
    .is_read  (cur_rd),
    .is_write (cur_wr),
    .offset   (offset),
    .err      (chk_err)
  );

  assign idx = offset[IDX_W-1:0];

  // The edge that moves the FSM into DONE is the one that performs the access.
  assign complete = (req_sel && request && (WAIT_CYCLES == 0)) ||
                    ((state == DMEM_WAIT) && (cnt == 4'd1));

  always_comb begin
    rd_word = '0;
    if (eff_size == SIZE_BYTE) begin
      rd_word[7:0] = mem[idx];
    end else begin
      for (int i = 0; i < BPW; i++) begin
        rd_word[DATA_WIDTH-1-8*i -: 8] = mem[idx + IDX_W'(i)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= DMEM_IDLE;
      cnt         <= '0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_size    <= SIZE_WORD;
      lat_rd      <= 1'b0;
      lat_wr      <= 1'b0;
      read_data_q <= '0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        DMEM_IDLE: begin
          if (request) begin
            lat_addr  <= bus.address;
            lat_wdata <= bus.WriteData;
            lat_size  <= bus.size;
            lat_rd    <= bus.MemRead;
            lat_wr    <= bus.MemWrite;
            cnt       <= 4'(WAIT_CYCLES);
            busy_q    <= 1'b1;
            state     <= (WAIT_CYCLES == 0) ? DMEM_DONE : DMEM_WAIT;
          end
        end
        DMEM_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= DMEM_DONE;
          end
        end
        DMEM_DONE: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          state   <= DMEM_IDLE;
        end
        default: begin
          state <= DMEM_IDLE;
        end
      endcase

      if (complete) begin
        ready_q <= 1'b1;
        err_q   <= chk_err;
        if (chk_err) begin
          read_data_q <= '0;
        end else if (cur_rd) begin
          read_data_q <= rd_word;
        end else if (cur_wr) begin
          if (eff_size == SIZE_BYTE) begin
            mem[idx] <= cur_wdata[7:0];
          end else begin
            for (int i = 0; i < BPW; i++) begin
              mem[idx + IDX_W'(i)] <= cur_wdata[DATA_WIDTH-1-8*i -: 8];
            end
          end
        end
      end
    end
  end

  assign bus.ReadData = read_data_q;
  assign bus.busy     = busy_q;
  assign bus.ready    = ready_q;
  assign bus.err      = err_q;
  assign fsm_state    = state;

endmodule

// File: tb/tb_data_memory_ws.sv
// Directed bench for data_memory_ws: one instance with no wait states, one with three.
module tb_data_memory_ws;
  import data_memory_ws_pkg::*;

  logic clk;
  logic rst0, rst3;
  dmem_state_t st0, st3;

  int n_checks = 0;
  int n_fail   = 0;

  data_memory_ws_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if0 ();
  data_memory_ws_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if3 ();

  data_memory_ws #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst0), .bus(if0.slave), .fsm_state(st0));
  data_memory_ws #(.WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst3), .bus(if3.slave), .fsm_state(st3));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int d, input logic rd, input logic wr, input logic sz,
                       input logic [31:0] a, input logic [31:0] w);
    if (d == 0) begin
      if0.MemRead = rd; if0.MemWrite = wr; if0.size = sz; if0.address = a; if0.WriteData = w;
    end else begin
      if3.MemRead = rd; if3.MemWrite = wr; if3.size = sz; if3.address = a; if3.WriteData = w;
    end
  endtask

  task automatic sample(input int d, output logic rdy, output logic er, output logic bsy,
                        output logic [31:0] rdat, output logic [31:0] st);
    if (d == 0) begin
      rdy = if0.ready; er = if0.err; bsy = if0.busy; rdat = if0.ReadData; st = 32'(st0);
    end else begin
      rdy = if3.ready; er = if3.err; bsy = if3.busy; rdat = if3.ReadData; st = 32'(st3);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Entered in an IDLE cycle (#1 after an edge); returns in the following IDLE cycle.
  task automatic access(input int d, input logic rd, input logic wr, input logic sz,
                        input logic [31:0] a, input logic [31:0] w, input int exp_lat,
                        input logic exp_err, input logic [31:0] exp_rd, input string tag);
    logic rdy, er, bsy;
    logic [31:0] rdat, st;
    int n;
    bit got;
    drive(d, rd, wr, sz, a, w);
    @(posedge clk); #1;
    drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n = 1;
    got = 0;
    while (n <= 20) begin
      sample(d, rdy, er, bsy, rdat, st);
      if (rdy) begin
        got = 1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    if (!got) begin
      check({tag, " ready_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, " latency"}, 32'(n), 32'(exp_lat));
      check({tag, " err"}, 32'(er), 32'(exp_err));
      check({tag, " rdata"}, rdat, exp_rd);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic        sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic rd, input logic wr, input logic sz, input logic [31:0] a,
                              input logic [31:0] w, input logic e, input logic [31:0] r);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sz = sz; v.addr = a; v.wdata = w; v.exp_err = e; v.exp_rdata = r;
    return v;
  endfunction

  // ---------------- main sequence / scoreboard ----------------
  initial begin
    logic rdy, er, bsy;
    logic [31:0] rdat, st;
    int busy_cnt, ready_cnt, ready_at;
    logic rdy_seen;

    // ReadData expectations assume it holds its value across stores.
    vecs[0]  = mk(0, 1, 0, 32'd1028, 32'hDEADBEEF, 0, 32'h00000000);
    vecs[1]  = mk(1, 0, 0, 32'd1028, 32'h0,        0, 32'hDEADBEEF);
    vecs[2]  = mk(1, 0, 0, 32'd1026, 32'h0,        1, 32'h00000000);
    vecs[3]  = mk(1, 0, 0, 32'd1028, 32'h0,        0, 32'hDEADBEEF);
    vecs[4]  = mk(0, 1, 0, 32'd1020, 32'h12345678, 1, 32'h00000000);
    vecs[5]  = mk(1, 0, 0, 32'd1028, 32'h0,        0, 32'hDEADBEEF);
    vecs[6]  = mk(0, 1, 0, 32'd1088, 32'h55555555, 1, 32'h00000000);
    vecs[7]  = mk(0, 1, 0, 32'd1084, 32'hCAFEF00D, 0, 32'h00000000);
    vecs[8]  = mk(1, 0, 0, 32'd1084, 32'h0,        0, 32'hCAFEF00D);
    vecs[9]  = mk(1, 1, 0, 32'd1028, 32'h99999999, 1, 32'h00000000);
    vecs[10] = mk(1, 0, 0, 32'd1028, 32'h0,        0, 32'hDEADBEEF);
    vecs[11] = mk(1, 0, 0, 32'd1024, 32'h0,        0, 32'h00000000);
    vecs[12] = mk(0, 1, 0, 32'd1028, 32'h11223344, 0, 32'h00000000);
`ifdef DMEM_BYTE_ACCESS_EN
    vecs[13] = mk(0, 1, 1, 32'd1031, 32'hFFFFFF5A, 0, 32'h00000000);
    vecs[14] = mk(1, 0, 0, 32'd1028, 32'h0,        0, 32'h1122335A);
    vecs[15] = mk(1, 0, 1, 32'd1029, 32'h0,        0, 32'h00000022);
    vecs[16] = mk(1, 0, 1, 32'd1087, 32'h0,        0, 32'h0000000D);
    vecs[17] = mk(1, 0, 1, 32'd1088, 32'h0,        1, 32'h00000000);
`else
    vecs[13] = mk(0, 1, 1, 32'd1031, 32'hFFFFFF5A, 1, 32'h00000000);
    vecs[14] = mk(1, 0, 0, 32'd1028, 32'h0,        0, 32'h11223344);
    vecs[15] = mk(1, 0, 1, 32'd1029, 32'h0,        1, 32'h00000000);
    vecs[16] = mk(1, 0, 1, 32'd1028, 32'h0,        0, 32'h11223344);
    vecs[17] = mk(1, 0, 1, 32'd1088, 32'h0,        1, 32'h00000000);
`endif

    rst0 = 1'b1;
    rst3 = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0;
    rst3 = 1'b0;

    for (int d = 0; d < 2; d++) begin
      sample(d, rdy, er, bsy, rdat, st);
      check($sformatf("reset%0d ready", d), 32'(rdy), 32'd0);
      check($sformatf("reset%0d err", d), 32'(er), 32'd0);
      check($sformatf("reset%0d busy", d), 32'(bsy), 32'd0);
      check($sformatf("reset%0d rdata", d), rdat, 32'd0);
      check($sformatf("reset%0d state", d), st, 32'(DMEM_IDLE));
    end

    // Table vectors on the zero-wait instance.
    for (int i = 0; i < NVEC; i++) begin
      access(0, vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].wdata, 1,
             vecs[i].exp_err, vecs[i].exp_rdata, $sformatf("vec%0d", i));
      if (i == 1) begin
        check("byte4", 32'(dut0.mem[4]), 32'h000000DE);
        check("byte5", 32'(dut0.mem[5]), 32'h000000AD);
        check("byte6", 32'(dut0.mem[6]), 32'h000000BE);
        check("byte7", 32'(dut0.mem[7]), 32'h000000EF);
      end
      if (i == 4) begin
        check("no_write_below_base", 32'(dut0.mem[0]), 32'h00000000);
      end
    end

    // Three wait states: busy/ready timing, and a mid-wait write that must be ignored.
    drive(1, 1'b1, 1'b0, 1'b0, 32'd1024, 32'h0);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    busy_cnt = 0;
    ready_cnt = 0;
    ready_at = 0;
    for (int n = 1; n <= 8; n++) begin
      sample(1, rdy, er, bsy, rdat, st);
      if (bsy) busy_cnt++;
      if (rdy) begin
        ready_cnt++;
        if (ready_at == 0) ready_at = n;
        check("ws3 rdata", rdat, 32'h0);
      end
      if (n == 2) drive(1, 1'b0, 1'b1, 1'b0, 32'd1024, 32'hFFFFFFFF);
      if (n == 3) drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
    end
    check("ws3 busy_cycles", 32'(busy_cnt), 32'd4);
    check("ws3 ready_cycle", 32'(ready_at), 32'd4);
    check("ws3 ready_pulses", 32'(ready_cnt), 32'd1);
    sample(1, rdy, er, bsy, rdat, st);
    check("ws3 idle_after", st, 32'(DMEM_IDLE));
    access(1, 1'b1, 1'b0, 1'b0, 32'd1024, 32'h0, 4, 1'b0, 32'h0, "ws3 ignored_write");
    access(1, 1'b1, 1'b0, 1'b0, 32'd1026, 32'h0, 4, 1'b1, 32'h0, "ws3 misaligned");

    // Reset while waiting on a store, with a request present during reset.
    rdy_seen = 1'b0;
    drive(1, 1'b0, 1'b1, 1'b0, 32'd1032, 32'hFFFFFFFF);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    sample(1, rdy, er, bsy, rdat, st);
    rdy_seen = rdy_seen | rdy;
    check("rst_wait state_wait", st, 32'(DMEM_WAIT));
    @(posedge clk); #1;
    sample(1, rdy, er, bsy, rdat, st);
    rdy_seen = rdy_seen | rdy;
    rst3 = 1'b1;
    drive(1, 1'b1, 1'b0, 1'b0, 32'd1024, 32'h0);
    @(posedge clk); #1;
    sample(1, rdy, er, bsy, rdat, st);
    rdy_seen = rdy_seen | rdy;
    check("rst_wait state_idle", st, 32'(DMEM_IDLE));
    check("rst_wait busy", 32'(bsy), 32'd0);
    check("rst_wait no_ready", 32'(rdy_seen), 32'd0);
    rst3 = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    access(1, 1'b1, 1'b0, 1'b0, 32'd1032, 32'h0, 4, 1'b0, 32'h0, "rst_wait readback");

    // Back-to-back on the zero-wait instance with the request held throughout.
    drive(0, 1'b0, 1'b1, 1'b0, 32'd1040, 32'hA5A5A5A5);
    @(posedge clk); #1;
    sample(0, rdy, er, bsy, rdat, st);
    check("b2b first_ready", 32'(rdy), 32'd1);
    check("b2b first_done", st, 32'(DMEM_DONE));
    drive(0, 1'b1, 1'b0, 1'b0, 32'd1040, 32'h0);
    @(posedge clk); #1;
    sample(0, rdy, er, bsy, rdat, st);
    check("b2b gap_ready", 32'(rdy), 32'd0);
    check("b2b gap_idle", st, 32'(DMEM_IDLE));
    @(posedge clk); #1;
    sample(0, rdy, er, bsy, rdat, st);
    check("b2b second_ready", 32'(rdy), 32'd1);
    check("b2b second_err", 32'(er), 32'd0);
    check("b2b second_rdata", rdat, 32'hA5A5A5A5);
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
